// File: rtl/ad5541_spi_rx_if.sv
// ad5541_spi_rx_if: serial pins and receiver outputs of the AD5541 SPI receiver.
// master = link driver / observer side, slave = receiver side.
interface ad5541_spi_rx_if;
    logic        csn;
    logic        sclk;
    logic        mosi;
    logic        ldac_n;
    logic [15:0] rx_data;
    logic        dv;
    logic        frame_err;
    logic [15:0] dac_code;
    logic        dac_upd;

    modport master (
        output csn, sclk, mosi, ldac_n,
        input  rx_data, dv, frame_err, dac_code, dac_upd
    );

    modport slave (
        input  csn, sclk, mosi, ldac_n,
        output rx_data, dv, frame_err, dac_code, dac_upd
    );
endinterface

// File: rtl/ad5541_spi_rx.sv
// ad5541_spi_rx: oversampled SPI slave receiver for the AD5541 serial protocol.
// Captures one 16-bit MSB-first word per chip-select frame into rx_data and
// transfers it to dac_code.
// Optional macro AD5541_RX_LDAC_EN: when defined, ldac_n governs the transfer
// (falling edge loads, held low is transparent); when undefined, ldac_n is
// ignored and every valid word is loaded immediately.
// SYNC_STAGES is legal in the range 2..4.
module ad5541_spi_rx #(
    parameter int SYNC_STAGES = 2
) (
    input logic            clk,
    input logic            reset_n,
    ad5541_spi_rx_if.slave bus
);
    typedef enum logic [1:0] {
        ST_WAIT_IDLE = 2'd0,
        ST_IDLE      = 2'd1,
        ST_SHIFT     = 2'd2
    } state_t;

    localparam logic [4:0] BITS_FULL   = 5'd16;
    localparam logic [4:0] BITS_SAT    = 5'd17;
    // Cycles needed before the synchroniser and edge flop hold post-reset samples.
    localparam logic [2:0] SETTLE_DONE = 3'(SYNC_STAGES + 1);

    logic [SYNC_STAGES-1:0] csn_sync_r;
    logic [SYNC_STAGES-1:0] sclk_sync_r;
    logic [SYNC_STAGES-1:0] mosi_sync_r;
    logic                   csn_prev_r;
    logic                   sclk_prev_r;
    logic                   csn_s;
    logic                   sclk_s;
    logic                   mosi_s;
    logic                   csn_fall_s;
    logic                   csn_rise_s;
    logic                   sclk_rise_s;

    state_t      state_r,     state_nxt_s;
    logic [2:0]  settle_r,    settle_nxt_s;
    logic [15:0] shift_r,     shift_nxt_s;
    logic [4:0]  bit_cnt_r,   bit_cnt_nxt_s;
    logic [15:0] rx_data_r,   rx_data_nxt_s;
    logic        dv_r,        dv_nxt_s;
    logic        frame_err_r, frame_err_nxt_s;
    logic [15:0] dac_code_r,  dac_code_nxt_s;
    logic        dac_upd_r,   dac_upd_nxt_s;
    logic [15:0] shift_upd_s;
    logic [4:0]  bit_cnt_upd_s;

    // Bring the asynchronous pins into the clk domain and keep one delayed copy for edges.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            csn_sync_r  <= {SYNC_STAGES{1'b1}};
            sclk_sync_r <= {SYNC_STAGES{1'b0}};
            mosi_sync_r <= {SYNC_STAGES{1'b1}};
            csn_prev_r  <= 1'b1;
            sclk_prev_r <= 1'b0;
        end else begin
            csn_sync_r  <= {csn_sync_r[SYNC_STAGES-2:0], bus.csn};
            sclk_sync_r <= {sclk_sync_r[SYNC_STAGES-2:0], bus.sclk};
            mosi_sync_r <= {mosi_sync_r[SYNC_STAGES-2:0], bus.mosi};
            csn_prev_r  <= csn_sync_r[SYNC_STAGES-1];
            sclk_prev_r <= sclk_sync_r[SYNC_STAGES-1];
        end
    end

    assign csn_s       = csn_sync_r[SYNC_STAGES-1];
    assign sclk_s      = sclk_sync_r[SYNC_STAGES-1];
    assign mosi_s      = mosi_sync_r[SYNC_STAGES-1];
    assign csn_fall_s  = csn_prev_r & ~csn_s;
    assign csn_rise_s  = ~csn_prev_r & csn_s;
    assign sclk_rise_s = ~sclk_prev_r & sclk_s;

`ifdef AD5541_RX_LDAC_EN
    logic [SYNC_STAGES-1:0] ldac_sync_r;
    logic                   ldac_prev_r;
    logic                   ldac_s;
    logic                   ldac_fall_s;

    // Synchronise ldac_n and keep one delayed copy to detect its falling edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ldac_sync_r <= {SYNC_STAGES{1'b1}};
            ldac_prev_r <= 1'b1;
        end else begin
            ldac_sync_r <= {ldac_sync_r[SYNC_STAGES-2:0], bus.ldac_n};
            ldac_prev_r <= ldac_sync_r[SYNC_STAGES-1];
        end
    end

    assign ldac_s      = ldac_sync_r[SYNC_STAGES-1];
    assign ldac_fall_s = ldac_prev_r & ~ldac_s;
`endif

    // State, datapath and output registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r     <= ST_WAIT_IDLE;
            settle_r    <= 3'd0;
            shift_r     <= 16'd0;
            bit_cnt_r   <= 5'd0;
            rx_data_r   <= 16'd0;
            dv_r        <= 1'b0;
            frame_err_r <= 1'b0;
            dac_code_r  <= 16'd0;
            dac_upd_r   <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            settle_r    <= settle_nxt_s;
            shift_r     <= shift_nxt_s;
            bit_cnt_r   <= bit_cnt_nxt_s;
            rx_data_r   <= rx_data_nxt_s;
            dv_r        <= dv_nxt_s;
            frame_err_r <= frame_err_nxt_s;
            dac_code_r  <= dac_code_nxt_s;
            dac_upd_r   <= dac_upd_nxt_s;
        end
    end

    // Frame sequencing, bit capture and DAC register transfer.
    always_comb begin
        state_nxt_s     = state_r;
        settle_nxt_s    = settle_r;
        shift_nxt_s     = shift_r;
        bit_cnt_nxt_s   = bit_cnt_r;
        rx_data_nxt_s   = rx_data_r;
        dv_nxt_s        = 1'b0;
        frame_err_nxt_s = 1'b0;
        dac_code_nxt_s  = dac_code_r;
        dac_upd_nxt_s   = 1'b0;
        shift_upd_s     = {shift_r[14:0], mosi_s};
        bit_cnt_upd_s   = (bit_cnt_r == BITS_SAT) ? BITS_SAT : (bit_cnt_r + 5'd1);

        case (state_r)
            ST_WAIT_IDLE: begin
                // The synchroniser resets to "csn high", so its first outputs after
                // reset are not real samples; only trust csn once they are.
                if (settle_r != SETTLE_DONE) begin
                    settle_nxt_s = settle_r + 3'd1;
                end else if (csn_s && csn_prev_r) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_WAIT_IDLE;
                end
            end
            ST_IDLE: begin
                if (csn_fall_s) begin
                    shift_nxt_s   = 16'd0;
                    bit_cnt_nxt_s = 5'd0;
                    state_nxt_s   = ST_SHIFT;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                // Shift first so a bit arriving with csn rising is counted in this frame.
                if (sclk_rise_s) begin
                    shift_nxt_s   = shift_upd_s;
                    bit_cnt_nxt_s = bit_cnt_upd_s;
                end else begin
                    shift_nxt_s   = shift_r;
                    bit_cnt_nxt_s = bit_cnt_r;
                end
                if (csn_rise_s) begin
                    state_nxt_s = ST_IDLE;
                    if (bit_cnt_nxt_s == BITS_FULL) begin
                        rx_data_nxt_s = shift_nxt_s;
                        dv_nxt_s      = 1'b1;
                    end else begin
                        frame_err_nxt_s = 1'b1;
                    end
                end else begin
                    state_nxt_s = ST_SHIFT;
                end
            end
            default: begin
                state_nxt_s = ST_WAIT_IDLE;
            end
        endcase

`ifdef AD5541_RX_LDAC_EN
        // LDAC held low makes the DAC register transparent to a new word.
        if (dv_nxt_s && !ldac_s) begin
            dac_code_nxt_s = rx_data_nxt_s;
            dac_upd_nxt_s  = 1'b1;
        end else if (ldac_fall_s) begin
            dac_code_nxt_s = rx_data_r;
            dac_upd_nxt_s  = 1'b1;
        end else begin
            dac_code_nxt_s = dac_code_r;
        end
`else
        if (dv_nxt_s) begin
            dac_code_nxt_s = rx_data_nxt_s;
            dac_upd_nxt_s  = 1'b1;
        end else begin
            dac_code_nxt_s = dac_code_r;
        end
`endif
    end

    assign bus.rx_data   = rx_data_r;
    assign bus.dv        = dv_r;
    assign bus.frame_err = frame_err_r;
    assign bus.dac_code  = dac_code_r;
    assign bus.dac_upd   = dac_upd_r;
endmodule
